// File: rtl/numbo_regfile.sv
// Eight BCD digit registers stepped by an instruction thread (run mode) or
// by two push-buttons (edit mode), with zero/overflow/underflow flags and a display scan.
module numbo_regfile #(
    parameter int SCAN_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 dostep,
    input  logic [7:0]           inc_regs,
    input  logic [7:0]           dec_regs,
    input  logic                 running,
    input  logic [2:0]           edit_sel,
    input  logic                 edit_up,
    input  logic                 edit_down,
    output logic [7:0]           reg_0,
    output logic                 step_done,
    output logic [7:0]           ovf,
    output logic [7:0]           udf,
    output logic [2:0]           disp_sel,
    output logic [3:0]           disp_val
);

    logic [3:0]           regs     [8];
    logic [3:0]           regs_nxt [8];
    logic [7:0]           ovf_nxt;
    logic [7:0]           udf_nxt;
    logic [7:0]           zero_nxt;
    logic                 dostep_q;
    logic                 running_q;
    logic [2:0]           up_sh;
    logic [2:0]           down_sh;
    logic [SCAN_BITS-1:0] presc;

    logic step_fire;
    logic run_rise;
    logic up_edge;
    logic down_edge;

    // Histories reset high so levels held across reset release look like no edge.
    assign step_fire = dostep & ~dostep_q & running;
    assign run_rise  = running & ~running_q;
    assign up_edge   = up_sh[1] & ~up_sh[2];
    assign down_edge = down_sh[1] & ~down_sh[2];

    always_comb begin
        regs_nxt = regs;
        ovf_nxt  = ovf;
        udf_nxt  = udf;
        if (step_fire) begin
            for (int i = 0; i < 8; i++) begin
                case ({inc_regs[i], dec_regs[i]})
                    2'b10: begin
                        if (regs[i] >= 4'd9) begin
                            regs_nxt[i] = 4'd0;
                            ovf_nxt[i]  = 1'b1;
                        end else begin
                            regs_nxt[i] = regs[i] + 4'd1;
                        end
                    end
                    2'b01: begin
                        if (regs[i] == 4'd0) begin
                            udf_nxt[i] = 1'b1;
                        end else begin
                            regs_nxt[i] = regs[i] - 4'd1;
                        end
                    end
                    default: regs_nxt[i] = regs[i];
                endcase
            end
        end else if (!running && (up_edge ^ down_edge)) begin
            if (up_edge) begin
                regs_nxt[edit_sel] = (regs[edit_sel] >= 4'd9) ? 4'd0 : regs[edit_sel] + 4'd1;
            end else begin
                regs_nxt[edit_sel] = (regs[edit_sel] == 4'd0) ? 4'd9 : regs[edit_sel] - 4'd1;
            end
        end
        // Entering run mode starts a fresh flag window; the clear wins over any set.
        if (run_rise) begin
            ovf_nxt = 8'h00;
            udf_nxt = 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            zero_nxt[i] = (regs_nxt[i] == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 4'd0;
            end
            reg_0     <= 8'hFF;
            ovf       <= 8'h00;
            udf       <= 8'h00;
            step_done <= 1'b0;
            dostep_q  <= 1'b1;
            running_q <= 1'b1;
            up_sh     <= 3'b111;
            down_sh   <= 3'b111;
        end else begin
            regs      <= regs_nxt;
            reg_0     <= zero_nxt;
            ovf       <= ovf_nxt;
            udf       <= udf_nxt;
            step_done <= step_fire;
            dostep_q  <= dostep;
            running_q <= running;
            up_sh     <= {up_sh[1:0], edit_up};
            down_sh   <= {down_sh[1:0], edit_down};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            presc    <= '0;
            disp_sel <= 3'd0;
        end else begin
            presc <= presc + {{(SCAN_BITS-1){1'b0}}, 1'b1};
            if (presc == {SCAN_BITS{1'b1}}) begin
                disp_sel <= disp_sel + 3'd1;
            end
        end
    end

    assign disp_val = regs[disp_sel];

endmodule

// File: tb/tb_numbo_regfile.sv
// Directed bench for numbo_regfile: stepping, flags, edit buttons, reset and display scan.
module tb_numbo_regfile;

    logic       clk = 1'b0;
    logic       rstb;
    logic       dostep;
    logic [7:0] inc_regs;
    logic [7:0] dec_regs;
    logic       running;
    logic [2:0] edit_sel;
    logic       edit_up;
    logic       edit_down;
    logic [7:0] reg_0;
    logic       step_done;
    logic [7:0] ovf;
    logic [7:0] udf;
    logic [2:0] disp_sel;
    logic [3:0] disp_val;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int m [8];

    numbo_regfile #(.SCAN_BITS(2)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .dostep    (dostep),
        .inc_regs  (inc_regs),
        .dec_regs  (dec_regs),
        .running   (running),
        .edit_sel  (edit_sel),
        .edit_up   (edit_up),
        .edit_down (edit_down),
        .reg_0     (reg_0),
        .step_done (step_done),
        .ovf       (ovf),
        .udf       (udf),
        .disp_sel  (disp_sel),
        .disp_val  (disp_val)
    );

    // clock / reset-relative cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rstb) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] zero_flags();
        logic [7:0] z;
        for (int i = 0; i < 8; i++) z[i] = (m[i] == 0);
        return z;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_reg%0d", tag, i), 32'(dut.regs[i]), 32'(m[i]));
        check({tag, "_reg_0"}, 32'(reg_0), 32'(zero_flags()));
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise dostep one cycle; returns at the falling edge after the step edge.
    task automatic do_step(input logic [7:0] inc, input logic [7:0] dec);
        @(negedge clk);
        inc_regs = inc;
        dec_regs = dec;
        dostep   = 1'b1;
        @(negedge clk);
        dostep   = 1'b0;
    endtask

    task automatic press(input logic up, input logic [2:0] sel);
        @(negedge clk);
        edit_sel = sel;
        if (up) edit_up = 1'b1;
        else    edit_down = 1'b1;
        idle(4);
        edit_up   = 1'b0;
        edit_down = 1'b0;
        idle(4);
    endtask

    initial begin
        int cnt;
        rstb = 1'b0; dostep = 1'b0; inc_regs = 8'h00; dec_regs = 8'h00;
        running = 1'b1; edit_sel = 3'd0; edit_up = 1'b0; edit_down = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = 0;
        idle(2);
        check("rst_reg_0", 32'(reg_0), 32'hFF);
        check("rst_ovf", 32'(ovf), 32'h00);
        check("rst_udf", 32'(udf), 32'h00);
        check("rst_step_done", 32'(step_done), 32'h0);
        check("rst_disp_sel", 32'(disp_sel), 32'h0);
        rstb = 1'b1;
        idle(2);

        // single increment of reg 0
        inc_regs = 8'h01;
        dostep = 1'b1;
        check("pre_step_reg_0", 32'(reg_0), 32'hFF);
        @(negedge clk);
        dostep = 1'b0;
        m[0] = 1;
        check("inc0_step_done", 32'(step_done), 32'h1);
        check("inc0_reg_0", 32'(reg_0), 32'hFE);
        check_regs("inc0");
        idle(1);
        check("inc0_step_done_off", 32'(step_done), 32'h0);

        // reg 3 up to 9, then wrap with overflow
        repeat (9) do_step(8'h08, 8'h00);
        m[3] = 9;
        check_regs("r3_nine");
        check("r3_nine_ovf", 32'(ovf), 32'h00);
        do_step(8'h08, 8'h00);
        m[3] = 0;
        check_regs("r3_wrap");
        check("r3_wrap_ovf", 32'(ovf), 32'h08);
        do_step(8'h00, 8'h20);
        check_regs("r5_dec");
        check("r5_dec_udf", 32'(udf), 32'h20);
        check("r5_dec_ovf", 32'(ovf), 32'h08);

        // dostep held high: exactly one step
        @(negedge clk);
        inc_regs = 8'h02;
        dostep = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_done) cnt++;
        end
        dostep = 1'b0;
        m[1] = 1;
        check("hold_pulses", 32'(cnt), 32'd1);
        check_regs("hold");

        // inc and dec together: no change, still a step
        do_step(8'h02, 8'h02);
        check("both_step_done", 32'(step_done), 32'h1);
        check_regs("both");
        check("both_ovf", 32'(ovf), 32'h08);
        check("both_udf", 32'(udf), 32'h20);

        // edit mode
        @(negedge clk);
        running = 1'b0;
        inc_regs = 8'h00;
        dec_regs = 8'h00;
        press(1'b1, 3'd2);
        press(1'b1, 3'd2);
        m[2] = 2;
        check_regs("edit_up");
        press(1'b0, 3'd4);
        m[4] = 9;
        check_regs("edit_down");
        check("edit_ovf_kept", 32'(ovf), 32'h08);
        check("edit_udf_kept", 32'(udf), 32'h20);
        // up and down together cancel
        @(negedge clk);
        edit_sel = 3'd2; edit_up = 1'b1; edit_down = 1'b1;
        idle(4);
        edit_up = 1'b0; edit_down = 1'b0;
        idle(4);
        check_regs("edit_both");
        // step request in edit mode is dropped
        do_step(8'hFF, 8'h00);
        check("edit_step_done", 32'(step_done), 32'h0);
        idle(1);
        check_regs("edit_step");
        @(negedge clk);
        running = 1'b1;
        @(negedge clk);
        check("run_ovf_clear", 32'(ovf), 32'h00);
        check("run_udf_clear", 32'(udf), 32'h00);
        check("run_no_defer", 32'(step_done), 32'h0);
        check_regs("run_back");
        // buttons ignored while running
        press(1'b1, 3'd0);
        check_regs("run_button");

        // display scan
        for (int i = 0; i < 36; i++) begin
            int es;
            @(negedge clk);
            es = (cyc / 4) % 8;
            check($sformatf("scan_sel_%0d", i), 32'(disp_sel), 32'(es));
            check($sformatf("scan_val_%0d", i), 32'(disp_val), 32'(m[es]));
        end

        // reset during a step request and mid-scan
        @(negedge clk);
        rstb = 1'b0;
        inc_regs = 8'hFF;
        dostep = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) m[i] = 0;
        check("mid_rst_step_done", 32'(step_done), 32'h0);
        check("mid_rst_disp_sel", 32'(disp_sel), 32'h0);
        check_regs("mid_rst");
        rstb = 1'b1;
        idle(1);
        check("rel_step_done", 32'(step_done), 32'h0);
        idle(2);
        check_regs("rel_held");
        check("rel_ovf", 32'(ovf), 32'h00);
        dostep = 1'b0;
        do_step(8'h01, 8'h00);
        m[0] = 1;
        check("post_rst_step_done", 32'(step_done), 32'h1);
        check_regs("post_rst");
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
